// File: rtl/bus_pkg.sv
// bus_pkg: bus source indices, bus widths and arbiter state encoding
package bus_pkg;
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;
  localparam int N_BUS_SRC  = 24;
  localparam int BUS_SEL_W  = 5;
  typedef enum logic [1:0] {ST_IDLE, ST_GRANTED, ST_HELD} arb_state_e;
endpackage

// File: rtl/bus_source_arbiter_if.sv
// bus_source_arbiter_if: request/grant bundle between control unit strobes and the bus arbiter
interface bus_source_arbiter_if #(
  parameter int N_SRC = bus_pkg::N_BUS_SRC,
  parameter int SEL_W = $clog2(N_SRC),
  parameter int CNT_W = 8
);
  logic [N_SRC-1:0] req;
  logic             hold;
  logic [SEL_W-1:0] grant_sel;
  logic [N_SRC-1:0] grant_onehot;
  logic             grant_valid;
  logic             conflict;
  logic [CNT_W-1:0] conflict_cnt;
  modport master (output req, hold, input grant_sel, grant_onehot, grant_valid, conflict, conflict_cnt);
  modport slave (input req, hold, output grant_sel, grant_onehot, grant_valid, conflict, conflict_cnt);
endinterface

// File: rtl/rotating_priority_pick.sv
// rotating_priority_pick: first set request bit at or after base, wrapping modulo N
module rotating_priority_pick #(
  parameter int N = 24,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic         found,
  output logic [W-1:0] idx
);
  // scan offsets from farthest to nearest so the nearest set bit after base is kept last
  always_comb begin
    found = |req;
    idx = '0;
    for (int o = N - 1; o >= 0; o--) begin
      int j;
      j = int'(base) + o;
      j = j >= N ? j - N : j;
      if (req[j]) idx = W'(j);
    end
  end
endmodule

// File: rtl/bus_source_arbiter.sv
// bus_source_arbiter: registered fixed-priority / round-robin bus source arbiter with grant hold and conflict counting
module bus_source_arbiter
  import bus_pkg::*;
#(
  parameter int N_SRC   = N_BUS_SRC,
  parameter int SEL_W   = $clog2(N_SRC),
  parameter bit RR_MODE = 1'b0,
  parameter int CNT_W   = 8
) (
  input logic                 clk,
  input logic                 clr,
  bus_source_arbiter_if.slave bus
);
  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d, ptr_q, ptr_d, base, win;
  logic [N_SRC-1:0] onehot_q, onehot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d, found, multi, held;
  assign base  = RR_MODE ? ptr_q : '0;
  assign held  = state_q != ST_IDLE && bus.hold;
  assign multi = |(bus.req & (bus.req - N_SRC'(1)));
  rotating_priority_pick #(.N(N_SRC), .W(SEL_W)) u_pick (
    .req  (bus.req),
    .base (base),
    .found(found),
    .idx  (win)
  );
  // freeze an owned grant under hold, otherwise re-arbitrate; pointer advances only on a fresh grant
  always_comb begin
    state_d    = held ? ST_HELD : found ? ST_GRANTED : ST_IDLE;
    sel_d      = held ? sel_q : found ? win : '0;
    onehot_d   = held ? onehot_q : found ? N_SRC'(1) << win : '0;
    ptr_d      = (held || !found || !RR_MODE) ? ptr_q : win == SEL_W'(N_SRC - 1) ? '0 : win + SEL_W'(1);
    conflict_d = multi;
    cnt_d      = multi && !(&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // state, pointer and output registers; clr overrides hold and req
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      ptr_q      <= '0;
      onehot_q   <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      onehot_q   <= onehot_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end
  assign bus.grant_sel    = sel_q;
  assign bus.grant_onehot = onehot_q;
  assign bus.grant_valid  = state_q != ST_IDLE;
  assign bus.conflict     = conflict_q;
  assign bus.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_source_arbiter.sv
// tb_bus_source_arbiter: table-driven check of fixed, round-robin and narrow-counter arbiter instances
module tb_bus_source_arbiter;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  bus_source_arbiter_if #(.N_SRC(24), .SEL_W(5), .CNT_W(8)) if_f ();
  bus_source_arbiter_if #(.N_SRC(24), .SEL_W(5), .CNT_W(8)) if_r ();
  bus_source_arbiter_if #(.N_SRC(24), .SEL_W(5), .CNT_W(2)) if_s ();
  bus_source_arbiter #(.N_SRC(24), .SEL_W(5), .RR_MODE(1'b0), .CNT_W(8)) u_fix (.clk(clk), .clr(clr), .bus(if_f));
  bus_source_arbiter #(.N_SRC(24), .SEL_W(5), .RR_MODE(1'b1), .CNT_W(8)) u_rr (.clk(clk), .clr(clr), .bus(if_r));
  bus_source_arbiter #(.N_SRC(24), .SEL_W(5), .RR_MODE(1'b0), .CNT_W(2)) u_sat (.clk(clk), .clr(clr), .bus(if_s));
  typedef struct {
    logic        clr;
    logic        hold;
    logic [23:0] req;
    int          sel_f;
    int          sel_r;
    logic        valid;
    logic        conf;
    int          cnt;
  } vec_t;
  vec_t v[26];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask
  task automatic drive(input logic c, input logic h, input logic [23:0] r);
    clr = c;
    if_f.req = r;
    if_r.req = r;
    if_s.req = r;
    if_f.hold = h;
    if_r.hold = h;
    if_s.hold = h;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input string tag, input int sf, input int sr, input logic vl, input logic cf, input int cn);
    int oh_f, oh_r, cs;
    oh_f = vl ? (1 << sf) : 0;
    oh_r = vl ? (1 << sr) : 0;
    cs = cn > 3 ? 3 : cn;
    chk({tag, " sel_fix"}, int'(if_f.grant_sel), sf);
    chk({tag, " sel_rr"}, int'(if_r.grant_sel), sr);
    chk({tag, " sel_sat"}, int'(if_s.grant_sel), sf);
    chk({tag, " onehot_fix"}, int'(if_f.grant_onehot), oh_f);
    chk({tag, " onehot_rr"}, int'(if_r.grant_onehot), oh_r);
    chk({tag, " valid_fix"}, int'(if_f.grant_valid), int'(vl));
    chk({tag, " valid_rr"}, int'(if_r.grant_valid), int'(vl));
    chk({tag, " conflict_fix"}, int'(if_f.conflict), int'(cf));
    chk({tag, " conflict_rr"}, int'(if_r.conflict), int'(cf));
    chk({tag, " cnt_fix"}, int'(if_f.conflict_cnt), cn);
    chk({tag, " cnt_rr"}, int'(if_r.conflict_cnt), cn);
    chk({tag, " cnt_sat"}, int'(if_s.conflict_cnt), cs);
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 24'hFFFFFF, 0, 0, 1'b0, 1'b0, 0};
    v[1]  = '{1'b1, 1'b0, 24'hFFFFFF, 0, 0, 1'b0, 1'b0, 0};
    v[2]  = '{1'b0, 1'b0, 24'h000000, 0, 0, 1'b0, 1'b0, 0};
    v[3]  = '{1'b0, 1'b1, 24'h000000, 0, 0, 1'b0, 1'b0, 0};
    v[4]  = '{1'b0, 1'b0, 24'h100020, 5, 5, 1'b1, 1'b1, 1};
    v[5]  = '{1'b0, 1'b0, 24'h800088, 3, 7, 1'b1, 1'b1, 2};
    v[6]  = '{1'b0, 1'b0, 24'h800088, 3, 23, 1'b1, 1'b1, 3};
    v[7]  = '{1'b0, 1'b0, 24'h800088, 3, 3, 1'b1, 1'b1, 4};
    v[8]  = '{1'b0, 1'b0, 24'h800088, 3, 7, 1'b1, 1'b1, 5};
    v[9]  = '{1'b0, 1'b0, 24'h200000, 21, 21, 1'b1, 1'b0, 5};
    v[10] = '{1'b0, 1'b1, 24'h000001, 21, 21, 1'b1, 1'b0, 5};
    v[11] = '{1'b0, 1'b1, 24'h000001, 21, 21, 1'b1, 1'b0, 5};
    v[12] = '{1'b0, 1'b1, 24'h000001, 21, 21, 1'b1, 1'b0, 5};
    v[13] = '{1'b0, 1'b0, 24'h000001, 0, 0, 1'b1, 1'b0, 5};
    v[14] = '{1'b0, 1'b1, 24'h000000, 0, 0, 1'b1, 1'b0, 5};
    v[15] = '{1'b0, 1'b1, 24'h000003, 0, 0, 1'b1, 1'b1, 6};
    v[16] = '{1'b0, 1'b0, 24'h000000, 0, 0, 1'b0, 1'b0, 6};
    v[17] = '{1'b0, 1'b0, 24'h010000, 16, 16, 1'b1, 1'b0, 6};
    v[18] = '{1'b0, 1'b1, 24'h010000, 16, 16, 1'b1, 1'b0, 6};
    v[19] = '{1'b1, 1'b1, 24'h010000, 0, 0, 1'b0, 1'b0, 0};
    v[20] = '{1'b0, 1'b0, 24'h010001, 0, 0, 1'b1, 1'b1, 1};
    v[21] = '{1'b0, 1'b0, 24'h800000, 23, 23, 1'b1, 1'b0, 1};
    v[22] = '{1'b0, 1'b0, 24'hC00000, 22, 22, 1'b1, 1'b1, 2};
    v[23] = '{1'b0, 1'b0, 24'hC00000, 22, 23, 1'b1, 1'b1, 3};
    v[24] = '{1'b0, 1'b0, 24'hC00000, 22, 22, 1'b1, 1'b1, 4};
    v[25] = '{1'b0, 1'b0, 24'h000000, 0, 0, 1'b0, 1'b0, 4};
    for (int i = 0; i < 26; i++) begin
      drive(v[i].clr, v[i].hold, v[i].req);
      check_all($sformatf("vec%0d", i), v[i].sel_f, v[i].sel_r, v[i].valid, v[i].conf, v[i].cnt);
    end
    drive(1'b0, 1'b0, 24'h000003);
    check_all("wrap0", 0, 0, 1'b1, 1'b1, 5);
    drive(1'b0, 1'b0, 24'h000003);
    check_all("wrap1", 0, 1, 1'b1, 1'b1, 6);
    drive(1'b0, 1'b0, 24'h000003);
    check_all("wrap2", 0, 0, 1'b1, 1'b1, 7);
    drive(1'b0, 1'b0, 24'h000000);
    check_all("drop", 0, 0, 1'b0, 1'b0, 7);
    drive(1'b0, 1'b1, 24'h000004);
    check_all("idle_hold", 2, 2, 1'b1, 1'b0, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
